// File: rtl/cache_arbiter.sv
// Two-requester arbiter sharing one physical memory port between the I-cache and D-cache.
// Define CACHE_ARBITER_ROUND_ROBIN_EN to alternate grants on simultaneous requests (default: D-cache wins).
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  d_req, pick_d;

  assign d_req = dcache_read | dcache_write;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
  // prio_d_q set means the D-cache wins the next tie (last grant went to the I-cache)
  logic prio_d_q, prio_d_d;
  assign pick_d = d_req & (~icache_read | prio_d_q);
`else
  assign pick_d = d_req;
`endif

  assign icache_rdata = pmem_rdata;
  assign dcache_rdata = pmem_rdata;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
      prio_d_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
      prio_d_q <= prio_d_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    prio_d_d    = prio_d_q;
`endif
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    icache_resp = 1'b0;
    dcache_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d  = SERVE_D;
          addr_d   = dcache_address;
          wdata_d  = dcache_wdata;
          write_d  = dcache_write;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
          prio_d_d = 1'b0;
`endif
        end else if (icache_read) begin
          state_d  = SERVE_I;
          addr_d   = icache_address;
          wdata_d  = '0;
          write_d  = 1'b0;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
          prio_d_d = 1'b1;
`endif
        end
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          icache_resp = 1'b1;
          state_d     = IDLE;
        end
      end
      SERVE_D: begin
        pmem_read  = ~write_q;
        pmem_write = write_q;
        if (pmem_resp) begin
          dcache_resp = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed cycle-by-cycle vectors for cache_arbiter plus a tie-break sequence.
module tb_cache_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         icache_read, dcache_read, dcache_write, pmem_resp;
  logic [15:0]  icache_address, dcache_address;
  logic [127:0] dcache_wdata, pmem_rdata;
  logic [127:0] icache_rdata, dcache_rdata, pmem_wdata;
  logic         icache_resp, dcache_resp, pmem_read, pmem_write;
  logic [15:0]  pmem_address;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic        rst, ir, dr, dw;
    logic [15:0] ia, da;
    logic [1:0]  wd;
    logic        pr;
    logic        epr, epw;
    logic [15:0] epa;
    logic [1:0]  ewd;
    logic        eir, edr;
  } vec_t;

  localparam int NV = 26;
  vec_t tv[NV];

  function automatic logic [127:0] wval(logic [1:0] c);
    case (c)
      2'd1:    wval = {16{8'h55}};
      2'd2:    wval = {16{8'h33}};
      default: wval = '0;
    endcase
  endfunction

  function automatic vec_t mk(logic r, logic ir, logic dr, logic dw, logic [15:0] ia,
                              logic [15:0] da, logic [1:0] wd, logic pr, logic epr,
                              logic epw, logic [15:0] epa, logic [1:0] ewd,
                              logic eir, logic edr);
    vec_t v;
    v.rst = r; v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.wd = wd;
    v.pr = pr; v.epr = epr; v.epw = epw; v.epa = epa; v.ewd = ewd;
    v.eir = eir; v.edr = edr;
    return v;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    //            rst ir dr dw ia       da       wd pr | epr epw epa      ewd eir edr
    tv[0]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h0000, 0, 0, 0);
    tv[1]  = mk(0, 1, 0, 0, 16'h1230, 16'h0000, 0, 0,   0, 0, 16'h0000, 0, 0, 0);
    tv[2]  = mk(0, 1, 0, 0, 16'h1230, 16'h0000, 0, 0,   1, 0, 16'h1230, 0, 0, 0);
    tv[3]  = mk(0, 1, 0, 0, 16'h1230, 16'h0000, 0, 0,   1, 0, 16'h1230, 0, 0, 0);
    tv[4]  = mk(0, 1, 0, 0, 16'h1230, 16'h0000, 0, 1,   1, 0, 16'h1230, 0, 1, 0);
    tv[5]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h1230, 0, 0, 0);
    tv[6]  = mk(0, 0, 0, 1, 16'h0000, 16'h4000, 1, 0,   0, 0, 16'h1230, 0, 0, 0);
    tv[7]  = mk(0, 0, 0, 1, 16'h0000, 16'h4000, 1, 0,   0, 1, 16'h4000, 1, 0, 0);
    tv[8]  = mk(0, 0, 0, 1, 16'h0000, 16'h4000, 1, 1,   0, 1, 16'h4000, 1, 0, 1);
    tv[9]  = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h4000, 1, 0, 0);
    tv[10] = mk(0, 1, 0, 0, 16'h2000, 16'h0000, 0, 0,   0, 0, 16'h4000, 1, 0, 0);
    tv[11] = mk(0, 1, 0, 0, 16'hFFFE, 16'h0000, 0, 0,   1, 0, 16'h2000, 0, 0, 0);
    tv[12] = mk(0, 1, 0, 1, 16'hFFFE, 16'h1111, 2, 0,   1, 0, 16'h2000, 0, 0, 0);
    tv[13] = mk(0, 0, 0, 1, 16'hFFFE, 16'h1111, 2, 1,   1, 0, 16'h2000, 0, 1, 0);
    tv[14] = mk(0, 0, 0, 1, 16'h0000, 16'h1111, 2, 0,   0, 0, 16'h2000, 0, 0, 0);
    tv[15] = mk(0, 0, 0, 1, 16'h0000, 16'h1111, 2, 0,   0, 1, 16'h1111, 2, 0, 0);
    tv[16] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1,   0, 1, 16'h1111, 2, 0, 1);
    tv[17] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1,   0, 0, 16'h1111, 2, 0, 0);
    tv[18] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h1111, 2, 0, 0);
    tv[19] = mk(0, 0, 1, 1, 16'h0000, 16'h3000, 1, 0,   0, 0, 16'h1111, 2, 0, 0);
    tv[20] = mk(0, 0, 1, 1, 16'h0000, 16'h3000, 1, 0,   0, 1, 16'h3000, 1, 0, 0);
    tv[21] = mk(0, 0, 1, 1, 16'h0000, 16'h3000, 1, 1,   0, 1, 16'h3000, 1, 0, 1);
    tv[22] = mk(0, 0, 1, 0, 16'h0000, 16'h5000, 2, 0,   0, 0, 16'h3000, 1, 0, 0);
    tv[23] = mk(1, 0, 1, 0, 16'h0000, 16'h5000, 2, 0,   1, 0, 16'h5000, 2, 0, 0);
    tv[24] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1,   0, 0, 16'h0000, 0, 0, 0);
    tv[25] = mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0,   0, 0, 16'h0000, 0, 0, 0);

    rst = 1'b1; icache_read = 0; dcache_read = 0; dcache_write = 0; pmem_resp = 0;
    icache_address = '0; dcache_address = '0; dcache_wdata = '0;
    pmem_rdata = {16{8'hAA}};
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      rst = tv[i].rst; icache_read = tv[i].ir; dcache_read = tv[i].dr;
      dcache_write = tv[i].dw; icache_address = tv[i].ia; dcache_address = tv[i].da;
      dcache_wdata = wval(tv[i].wd); pmem_resp = tv[i].pr;
      #4;
      chk($sformatf("v%0d pmem_read", i), 128'(pmem_read), 128'(tv[i].epr));
      chk($sformatf("v%0d pmem_write", i), 128'(pmem_write), 128'(tv[i].epw));
      chk($sformatf("v%0d pmem_address", i), 128'(pmem_address), 128'(tv[i].epa));
      chk($sformatf("v%0d pmem_wdata", i), pmem_wdata, wval(tv[i].ewd));
      chk($sformatf("v%0d icache_resp", i), 128'(icache_resp), 128'(tv[i].eir));
      chk($sformatf("v%0d dcache_resp", i), 128'(dcache_resp), 128'(tv[i].edr));
      if (tv[i].eir) chk($sformatf("v%0d icache_rdata", i), icache_rdata, {16{8'hAA}});
      if (tv[i].edr) chk($sformatf("v%0d dcache_rdata", i), dcache_rdata, {16{8'hAA}});
      @(posedge clk);
      #1;
    end

    // Tie-break: both caches request on the same edge, twice in a row from reset
    rst = 1'b1; pmem_resp = 0; icache_read = 0; dcache_read = 0; dcache_write = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      logic exp_d;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
      exp_d = (r == 0);
`else
      exp_d = 1'b1;
`endif
      icache_read = 1; dcache_read = 1;
      icache_address = 16'h0100; dcache_address = 16'h0200;
      #4;
      chk($sformatf("tie%0d idle strobe", r), 128'(pmem_read), 128'(0));
      @(posedge clk);
      #1;
      chk($sformatf("tie%0d grant addr", r), 128'(pmem_address),
          128'(exp_d ? 16'h0200 : 16'h0100));
      chk($sformatf("tie%0d pmem_read", r), 128'(pmem_read), 128'(1));
      pmem_resp = 1;
      #1;
      chk($sformatf("tie%0d dcache_resp", r), 128'(dcache_resp), 128'(exp_d));
      chk($sformatf("tie%0d icache_resp", r), 128'(icache_resp), 128'(!exp_d));
      @(posedge clk);
      #1;
      pmem_resp = 0; icache_read = 0; dcache_read = 0;
      #4;
      chk($sformatf("tie%0d back idle", r), 128'(pmem_read), 128'(0));
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, 16, byte address width (lc3b_word).
REQ-002 Parameter: LINE_WIDTH, 128, cache line width in bits.
REQ-003 Clock and reset are fixed: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: icache_read  input  1  I-cache line-fill request; held until icache_resp.
REQ-007 Port: icache_address  input  ADDR_WIDTH  I-cache line address.
REQ-008 Port: icache_rdata  output  LINE_WIDTH  line returned to the I-cache.
REQ-009 Port: icache_resp  output  1  one-cycle completion pulse to the I-cache.
REQ-010 Port: dcache_read / dcache_write  input  1 each  D-cache fill / writeback request; held until dcache_resp.
REQ-011 Port: dcache_address  input  ADDR_WIDTH  D-cache line address.
REQ-012 Port: dcache_wdata  input  LINE_WIDTH  writeback line.
REQ-013 Port: dcache_rdata  output  LINE_WIDTH  line returned to the D-cache.
REQ-014 Port: dcache_resp  output  1  one-cycle completion pulse to the D-cache.
REQ-015 Port: pmem_read / pmem_write  output  1 each  physical memory request strobes; held until pmem_resp.
REQ-016 Port: pmem_address  output  ADDR_WIDTH  latched address of the granted request.
REQ-017 Port: pmem_wdata  output  LINE_WIDTH  latched writeback line.
REQ-018 Port: pmem_rdata  input  LINE_WIDTH  line from memory.
REQ-019 Port: pmem_resp  input  1  memory completion pulse.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, SERVE_I and SERVE_D.
REQ-021 In IDLE, pmem_read, pmem_write, icache_resp and dcache_resp SHALL all be 0.
REQ-022 In IDLE with exactly one requester pending, the block SHALL latch that requester's address, wdata and operation, then enter its SERVE state on the next edge.
REQ-023 With both requesters pending in IDLE, the D-cache SHALL win (fixed priority), unless REQ-033 applies.
REQ-024 In a SERVE state, pmem_address, pmem_wdata and pmem_read/pmem_write SHALL be driven from the latched registers only; requester inputs changing mid-service SHALL have no effect.
REQ-025 Latency: a request seen in IDLE at cycle N SHALL produce a pmem strobe in cycle N+1.
REQ-026 pmem_resp in SERVE_x SHALL combinationally assert x_resp and drive x_rdata = pmem_rdata in the same cycle, and the FSM SHALL return to IDLE on that edge.
REQ-027 The non-granted requester's resp SHALL stay 0; its rdata is don't-care.
REQ-028 At least one IDLE cycle SHALL separate consecutive grants.
REQ-029 dcache_read and dcache_write asserted together SHALL be treated as a write.
REQ-030 pmem_resp received in IDLE SHALL be ignored.
REQ-031 A requester dropping its request before resp SHALL NOT abort the memory transaction; resp SHALL still pulse on completion.

Reset
REQ-032 With rst high at an edge, the state SHALL become IDLE, all latched registers SHALL become 0, and the priority flag SHALL become "D-cache next"; this holds even mid-transaction, and all strobes and resps SHALL be 0 in the following cycle.

Configuration
REQ-033 With macro CACHE_ARBITER_ROUND_ROBIN_EN defined, a last-grant flag SHALL be kept: on a simultaneous request in IDLE, the requester not granted last SHALL win, and the flag SHALL update on every grant. With the macro undefined, the flag SHALL be absent and REQ-023 fixed D priority SHALL apply.

Verification
REQ-034 icache_read=1, addr 0x1230; memory returns 0xAA..AA after 3 cycles -> pmem_read=1 with addr 0x1230 at cycle N+1; icache_resp pulses once with rdata 0xAA..AA; then IDLE.
REQ-035 dcache_write=1, addr 0x4000, wdata 0x55..55 -> pmem_write=1, pmem_wdata 0x55..55; dcache_resp pulses once; icache_resp stays 0.
REQ-036 icache_read and dcache_read both asserted at the same edge, repeated twice -> without the macro, D is granted both times; with the macro, the grants are D then I.
REQ-037 During SERVE_I, change icache_address to 0xFFFE -> pmem_address stays at the latched value until resp.
REQ-038 Assert rst during SERVE_D before pmem_resp -> the next cycle has pmem_read=pmem_write=0 and the state is IDLE; a late pmem_resp causes no resp pulse.
REQ-039 pmem_resp pulsed while in IDLE -> no resp output and no state change.
